// File: rtl/hz_pkg.sv
// Shared encodings for the hazard/control unit: EX operand forwarding selects
// and next-PC source selects.
package hz_pkg;

  typedef enum logic [1:0] {
    FWD_RF     = 2'b00,
    FWD_EXALU  = 2'b01,
    FWD_MEMALU = 2'b10,
    FWD_MEMLD  = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_JR  = 2'b10,
    PC_J   = 2'b11
  } pc_sel_e;

endpackage

// File: rtl/hz_scoreboard.sv
// Per-register countdown scoreboard: a non-zero count means the register's
// value is not yet readable from the register file.
module hz_scoreboard #(
  parameter int NREG  = 32,
  parameter int RW    = 5,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [RW-1:0]    set_idx,
  input  logic [CNT_W-1:0] set_val,
  input  logic [RW-1:0]    rs_idx,
  input  logic [RW-1:0]    rt_idx,
  input  logic [RW-1:0]    rd_idx,
  output logic [CNT_W-1:0] rs_cnt,
  output logic [CNT_W-1:0] rt_cnt,
  output logic [CNT_W-1:0] rd_cnt
);

  logic [CNT_W-1:0] cnt [NREG];

  // Register 0 is hard-wired zero and is never tracked; a set to the same
  // register in the cycle it would decrement takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (r == 0) begin
          cnt[r] <= '0;
        end else if (set_en && (set_idx == RW'(r))) begin
          cnt[r] <= set_val;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - 1'b1;
        end
      end
    end
  end

  assign rs_cnt = cnt[rs_idx];
  assign rt_cnt = cnt[rt_idx];
  assign rd_cnt = cnt[rd_idx];

endmodule

// File: rtl/hazard_ctrl_sb.sv
// Pipeline hazard/control unit beside ID: scoreboard-based stall, mul/div
// structural interlock, EX forwarding selects, PC redirect/flush and stall count.
module hazard_ctrl_sb
  import hz_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int RW       = 5,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 8,
  parameter int CNT_W    = 4,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [RW-1:0]     id_rs,
  input  logic [RW-1:0]     id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wreg,
  input  logic [RW-1:0]     id_rd,
  input  logic              id_is_load,
  input  logic              id_is_md,
  input  logic [1:0]        id_pcsel_req,
  input  logic              ex_wreg,
  input  logic              ex_m2reg,
  input  logic [RW-1:0]     ex_rn,
  input  logic              mem_wreg,
  input  logic              mem_m2reg,
  input  logic [RW-1:0]     mem_rn,
  output logic              stall,
  output logic              pc_we,
  output logic              ifid_we,
  output logic [1:0]        pcsel,
  output logic              flush_if,
  output logic [1:0]        fwda,
  output logic [1:0]        fwdb,
  output logic [PERF_W-1:0] stall_cycles
);

  logic [CNT_W-1:0] rs_cnt, rt_cnt, rd_cnt;
  logic [CNT_W-1:0] set_val;
  logic [CNT_W-1:0] md_busy;
  logic             set_en;
  logic             issue;
  logic             raw_rs, raw_rt, waw, md_struct;

  hz_scoreboard #(
    .NREG  (NREG),
    .RW    (RW),
    .CNT_W (CNT_W)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (set_en),
    .set_idx (id_rd),
    .set_val (set_val),
    .rs_idx  (id_rs),
    .rt_idx  (id_rt),
    .rd_idx  (id_rd),
    .rs_cnt  (rs_cnt),
    .rt_cnt  (rt_cnt),
    .rd_cnt  (rd_cnt)
  );

  assign raw_rs    = id_use_rs & (id_rs != '0) & (rs_cnt != '0);
  assign raw_rt    = id_use_rt & (id_rt != '0) & (rt_cnt != '0);
  assign waw       = id_wreg & (id_rd != '0) & (rd_cnt != '0);
  assign md_struct = id_is_md & (md_busy != '0);

  assign stall   = id_valid & (raw_rs | raw_rt | waw | md_struct);
  assign issue   = id_valid & ~stall;
  assign pc_we   = ~stall;
  assign ifid_we = ~stall;

  // Plain ALU results are forwarded, so their destinations need no countdown.
  assign set_en  = issue & id_wreg & (id_rd != '0);
  assign set_val = id_is_load ? CNT_W'(LOAD_LAT) :
                   id_is_md   ? CNT_W'(MD_LAT)   : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      md_busy <= '0;
    end else if (issue && id_is_md) begin
      md_busy <= CNT_W'(MD_LAT);
    end else if (md_busy != '0) begin
      md_busy <= md_busy - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

  // The younger producer in EX wins over MEM; a load still in EX has no data yet.
  function automatic logic [1:0] fwd_select(input logic [RW-1:0] src);
    logic ex_hit, mem_hit;
    ex_hit  = ex_wreg & (ex_rn != '0) & (ex_rn == src);
    mem_hit = mem_wreg & (mem_rn != '0) & (mem_rn == src);
    if (ex_hit && !ex_m2reg)        return FWD_EXALU;
    else if (mem_hit && !mem_m2reg) return FWD_MEMALU;
    else if (mem_hit && mem_m2reg)  return FWD_MEMLD;
    else                            return FWD_RF;
  endfunction

  assign fwda = fwd_select(id_rs);
  assign fwdb = fwd_select(id_rt);

  // A stalled control-transfer must neither redirect nor squash IF.
  assign pcsel    = issue ? id_pcsel_req : PC_SEQ;
  assign flush_if = issue & (id_pcsel_req != PC_SEQ);

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Directed scoreboard bench for hazard_ctrl_sb: the driver pushes the
// hand-computed response of each cycle, a negedge monitor pops and compares.
module tb_hazard_ctrl_sb;
  import hz_pkg::*;

  localparam int W = 42;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_use_rs, id_use_rt, id_wreg, id_is_load, id_is_md;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [1:0]  id_pcsel_req;
  logic        ex_wreg, ex_m2reg, mem_wreg, mem_m2reg;
  logic [4:0]  ex_rn, mem_rn;
  logic        stall, pc_we, ifid_we, flush_if;
  logic [1:0]  pcsel, fwda, fwdb;
  logic [31:0] stall_cycles;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           checks   = 0;
  int           failures = 0;
  logic [31:0]  exp_perf = '0;

  hazard_ctrl_sb dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_wreg      (id_wreg),
    .id_rd        (id_rd),
    .id_is_load   (id_is_load),
    .id_is_md     (id_is_md),
    .id_pcsel_req (id_pcsel_req),
    .ex_wreg      (ex_wreg),
    .ex_m2reg     (ex_m2reg),
    .ex_rn        (ex_rn),
    .mem_wreg     (mem_wreg),
    .mem_m2reg    (mem_m2reg),
    .mem_rn       (mem_rn),
    .stall        (stall),
    .pc_we        (pc_we),
    .ifid_we      (ifid_we),
    .pcsel        (pcsel),
    .flush_if     (flush_if),
    .fwda         (fwda),
    .fwdb         (fwdb),
    .stall_cycles (stall_cycles)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  // driver tasks
  task automatic clr();
    id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_wreg = 0; id_rd = 0; id_is_load = 0; id_is_md = 0; id_pcsel_req = PC_SEQ;
    ex_wreg = 0; ex_m2reg = 0; ex_rn = 0;
    mem_wreg = 0; mem_m2reg = 0; mem_rn = 0;
  endtask

  task automatic id_in(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                       input logic urt, input logic wr, input logic [4:0] rd,
                       input logic ld, input logic md, input logic [1:0] pcr);
    id_valid = 1; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
    id_wreg = wr; id_rd = rd; id_is_load = ld; id_is_md = md; id_pcsel_req = pcr;
  endtask

  task automatic ex_in(input logic w, input logic m, input logic [4:0] rn);
    ex_wreg = w; ex_m2reg = m; ex_rn = rn;
  endtask

  task automatic mem_in(input logic w, input logic m, input logic [4:0] rn);
    mem_wreg = w; mem_m2reg = m; mem_rn = rn;
  endtask

  // Push this cycle's expected outputs; stall_cycles shows stalls of earlier cycles only.
  task automatic cyc(input string name, input logic st, input logic [1:0] pc,
                     input logic fl, input logic [1:0] fa, input logic [1:0] fb);
    exp_q.push_back({st, ~st, ~st, pc, fl, fa, fb, exp_perf});
    tag_q.push_back(name);
    if (st && exp_perf != '1) exp_perf = exp_perf + 1;
    @(posedge clk);
    #1;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] e, a;
      string        t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {stall, pc_we, ifid_we, pcsel, flush_if, fwda, fwdb, stall_cycles};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got stall=%b pc_we=%b ifid_we=%b pcsel=%b flush=%b fwda=%b fwdb=%b perf=%0d, expected stall=%b pc_we=%b ifid_we=%b pcsel=%b flush=%b fwda=%b fwdb=%b perf=%0d",
                 t, a[41], a[40], a[39], a[38:37], a[36], a[35:34], a[33:32], a[31:0],
                 e[41], e[40], e[39], e[38:37], e[36], e[35:34], e[33:32], e[31:0]);
      end
    end
  end

  // stimulus
  initial begin
    clr();
    rst = 1;
    @(posedge clk); @(posedge clk); #1;
    rst = 0;

    clr(); cyc("reset_idle", 0, PC_SEQ, 0, FWD_RF, FWD_RF);

    // load-use with LOAD_LAT=1
    clr(); id_in(1, 1, 0, 0, 1, 2, 1, 0, PC_SEQ); cyc("lw2_issue", 0, PC_SEQ, 0, FWD_RF, FWD_RF);
    clr(); id_in(2, 1, 4, 1, 1, 3, 0, 0, PC_SEQ); ex_in(1, 1, 2);
    cyc("loaduse_stall", 1, PC_SEQ, 0, FWD_RF, FWD_RF);
    clr(); id_in(2, 1, 4, 1, 1, 3, 0, 0, PC_SEQ); mem_in(1, 1, 2);
    cyc("loaduse_issue", 0, PC_SEQ, 0, FWD_MEMLD, FWD_RF);

    // ALU forwarding
    clr(); id_in(1, 1, 1, 1, 1, 2, 0, 0, PC_SEQ); cyc("add2", 0, PC_SEQ, 0, FWD_RF, FWD_RF);
    clr(); id_in(2, 1, 2, 1, 1, 5, 0, 0, PC_SEQ); ex_in(1, 0, 2);
    cyc("fwd_ex", 0, PC_SEQ, 0, FWD_EXALU, FWD_EXALU);
    clr(); id_in(2, 1, 2, 1, 1, 5, 0, 0, PC_SEQ); mem_in(1, 0, 2);
    cyc("fwd_mem", 0, PC_SEQ, 0, FWD_MEMALU, FWD_MEMALU);
    clr(); id_in(2, 1, 7, 1, 1, 5, 0, 0, PC_SEQ); ex_in(1, 0, 2); mem_in(1, 0, 7);
    cyc("fwd_mixed", 0, PC_SEQ, 0, FWD_EXALU, FWD_MEMALU);
    clr(); id_in(2, 1, 2, 1, 1, 5, 0, 0, PC_SEQ); ex_in(1, 0, 2); mem_in(1, 1, 2);
    cyc("fwd_ex_priority", 0, PC_SEQ, 0, FWD_EXALU, FWD_EXALU);
    clr(); id_in(0, 1, 0, 1, 1, 5, 0, 0, PC_SEQ); ex_in(1, 0, 0); mem_in(1, 0, 0);
    cyc("fwd_r0", 0, PC_SEQ, 0, FWD_RF, FWD_RF);

    // mul result dependency: 8 stall cycles
    clr(); id_in(1, 0, 1, 0, 1, 6, 0, 1, PC_SEQ); cyc("mul6_issue", 0, PC_SEQ, 0, FWD_RF, FWD_RF);
    for (int i = 0; i < 8; i++) begin
      clr(); id_in(6, 1, 1, 1, 1, 7, 0, 0, PC_SEQ);
      cyc("md_raw_stall", 1, PC_SEQ, 0, FWD_RF, FWD_RF);
    end
    clr(); id_in(6, 1, 1, 1, 1, 7, 0, 0, PC_SEQ); cyc("md_raw_issue", 0, PC_SEQ, 0, FWD_RF, FWD_RF);

    // structural md_busy interlock, then WAW on the md destination
    clr(); id_in(1, 1, 2, 1, 1, 8, 0, 1, PC_SEQ); cyc("mul8_issue", 0, PC_SEQ, 0, FWD_RF, FWD_RF);
    for (int i = 0; i < 8; i++) begin
      clr(); id_in(3, 1, 4, 1, 1, 6, 0, 1, PC_SEQ);
      cyc("md_struct_stall", 1, PC_SEQ, 0, FWD_RF, FWD_RF);
    end
    clr(); id_in(3, 1, 4, 1, 1, 6, 0, 1, PC_SEQ); cyc("md_struct_issue", 0, PC_SEQ, 0, FWD_RF, FWD_RF);
    for (int i = 0; i < 8; i++) begin
      clr(); id_in(1, 1, 1, 1, 1, 6, 0, 0, PC_SEQ);
      cyc("waw_stall", 1, PC_SEQ, 0, FWD_RF, FWD_RF);
    end
    clr(); id_in(1, 1, 1, 1, 1, 6, 0, 0, PC_SEQ); cyc("waw_issue", 0, PC_SEQ, 0, FWD_RF, FWD_RF);

    // branch gating by stall, one-cycle flush, jr / jal
    clr(); id_in(1, 1, 0, 0, 1, 10, 1, 0, PC_SEQ); cyc("lw10_issue", 0, PC_SEQ, 0, FWD_RF, FWD_RF);
    clr(); id_in(10, 1, 0, 1, 0, 0, 0, 0, PC_BR); ex_in(1, 1, 10);
    cyc("br_stalled", 1, PC_SEQ, 0, FWD_RF, FWD_RF);
    clr(); id_in(10, 1, 0, 1, 0, 0, 0, 0, PC_BR); mem_in(1, 1, 10);
    cyc("br_issue", 0, PC_BR, 1, FWD_MEMLD, FWD_RF);
    clr(); id_pcsel_req = PC_BR; cyc("br_flushed_slot", 0, PC_SEQ, 0, FWD_RF, FWD_RF);
    clr(); id_in(31, 1, 0, 0, 0, 0, 0, 0, PC_JR); cyc("jr_issue", 0, PC_JR, 1, FWD_RF, FWD_RF);
    clr(); id_in(0, 0, 0, 0, 1, 31, 0, 0, PC_J); cyc("jal_issue", 0, PC_J, 1, FWD_RF, FWD_RF);
    clr(); id_in(1, 1, 0, 0, 1, 12, 1, 0, PC_SEQ); cyc("lw12_issue", 0, PC_SEQ, 0, FWD_RF, FWD_RF);
    clr(); id_rs = 12; id_use_rs = 1; cyc("invalid_no_stall", 0, PC_SEQ, 0, FWD_RF, FWD_RF);

    // mid-operation reset with cnt[9]=5 and md_busy pending
    clr(); id_in(1, 0, 1, 0, 1, 9, 0, 1, PC_SEQ); cyc("mul9_issue", 0, PC_SEQ, 0, FWD_RF, FWD_RF);
    for (int i = 0; i < 3; i++) begin
      clr(); cyc("idle_wait", 0, PC_SEQ, 0, FWD_RF, FWD_RF);
    end
    clr(); rst = 1;
    @(posedge clk); #1;
    rst = 0;
    exp_perf = '0;
    if (stall_cycles !== 32'd0) begin
      failures++;
      $display("FAIL post_rst_perf: stall_cycles=%0d expected 0", stall_cycles);
    end
    clr(); id_in(9, 1, 9, 1, 1, 11, 0, 0, PC_SEQ); cyc("post_rst_issue", 0, PC_SEQ, 0, FWD_RF, FWD_RF);
    clr(); id_in(1, 1, 1, 1, 1, 12, 0, 1, PC_SEQ); cyc("post_rst_md", 0, PC_SEQ, 0, FWD_RF, FWD_RF);

    // destination $0 is never tracked
    clr(); id_in(1, 1, 0, 0, 1, 0, 1, 0, PC_SEQ); cyc("lw_r0_issue", 0, PC_SEQ, 0, FWD_RF, FWD_RF);
    clr(); id_in(0, 1, 0, 1, 1, 0, 0, 0, PC_SEQ); cyc("r0_no_stall", 0, PC_SEQ, 0, FWD_RF, FWD_RF);

    // final report
    clr();
    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL final: %0d expected entries never compared", exp_q.size());
    end
    if (checks == 0) begin
      failures++;
      $display("FAIL final: no checks performed");
    end
    if (stall_cycles !== exp_perf) begin
      failures++;
      $display("FAIL final_perf: stall_cycles=%0d expected %0d", stall_cycles, exp_perf);
    end
    if (failures == 0) $display("PASS all checks");
    else               $display("FAIL %0d mismatches", failures);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
